// File: rtl/fixed_lut_activation_loader.sv
// Runtime-loadable fixed-point activation LUT: a write stream fills a per-lane table,
// then valid/ready lookups are served with one cycle of latency.
module fixed_lut_activation_loader #(
   parameter int DATA_IN_0_PRECISION_0       = 8,
   parameter int DATA_IN_0_PRECISION_1       = 4,
   parameter int DATA_OUT_0_PRECISION_0      = 8,
   parameter int DATA_OUT_0_PRECISION_1      = 4,
   parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
   parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_OUT_0_PRECISION_0-1:0] lut_wr_data,
   input  logic                              lut_wr_valid,
   output logic                              lut_wr_ready,
   input  logic                              lut_reload,
   output logic                              lut_loaded,
   input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
   input  logic                              data_in_0_valid,
   output logic                              data_in_0_ready,
   output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1],
   output logic                              data_out_0_valid,
   input  logic                              data_out_0_ready
);

   localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
   localparam int AW    = DATA_IN_0_PRECISION_0;
   localparam int OW    = DATA_OUT_0_PRECISION_0;
   localparam int DEPTH = 2 ** AW;
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] MSB_MASK  = AW'(1) << (AW - 1);

   if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0 ||
       DATA_OUT_0_PRECISION_1 > DATA_OUT_0_PRECISION_0) begin : g_bad_frac
      $error("fractional width exceeds word width");
   end

   typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DRAIN} state_t;

   state_t        r_state;
   logic [AW-1:0] r_wr_addr;
   logic [OW-1:0] r_table    [N][DEPTH];
   logic [OW-1:0] r_out_data [N];
   logic          r_out_valid;

   logic          w_wr_ready;
   logic          w_wr_hs;
   logic          w_in_ready;
   logic          w_in_hs;
   logic          w_out_hs;
   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_lut_addr [N];

   // NOTE: state already sits in LOAD during reset, so only the write-ready needs rst gating to read 0.
   assign w_wr_ready = !rst && (r_state == ST_LOAD);
   assign w_wr_hs    = lut_wr_valid && w_wr_ready;
   assign w_in_ready = (r_state == ST_RUN) && !lut_reload && (!r_out_valid || data_out_0_ready);
   assign w_in_hs    = data_in_0_valid && w_in_ready;
   assign w_out_hs   = r_out_valid && data_out_0_ready;
   // A beat arriving together with a reload becomes entry 0 of the fresh load.
   assign w_wr_idx   = lut_reload ? '0 : r_wr_addr;

   // Entry 0 holds the most negative input: flip the sign bit to get the offset address.
   always_comb begin
      for (int l = 0; l < N; l++) begin
         w_lut_addr[l] = data_in_0[l] ^ MSB_MASK;
      end
   end

   // NOTE: the table is plain storage with no reset; every reset is followed by a full reload.
   always_ff @(posedge clk) begin
      if (w_wr_hs) begin
         for (int l = 0; l < N; l++) begin
            r_table[l][w_wr_idx] <= lut_wr_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_LOAD;
         r_wr_addr   <= '0;
         r_out_valid <= 1'b0;
         for (int l = 0; l < N; l++) begin
            r_out_data[l] <= '0;
         end
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (lut_reload) begin
                  r_wr_addr <= w_wr_hs ? AW'(1) : '0;
               end else if (w_wr_hs) begin
                  if (r_wr_addr == LAST_ADDR) begin
                     r_state   <= ST_RUN;
                     r_wr_addr <= '0;
                  end else begin
                     r_wr_addr <= r_wr_addr + AW'(1);
                  end
               end
            end
            ST_RUN: begin
               if (w_in_hs) begin
                  r_out_valid <= 1'b1;
                  for (int l = 0; l < N; l++) begin
                     r_out_data[l] <= r_table[l][w_lut_addr[l]];
                  end
               end else if (w_out_hs) begin
                  r_out_valid <= 1'b0;
               end
               if (lut_reload) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // The pending beat leaves with old-table data before the table is overwritten.
               if (w_out_hs) begin
                  r_out_valid <= 1'b0;
               end
               if (!r_out_valid || data_out_0_ready) begin
                  r_state   <= ST_LOAD;
                  r_wr_addr <= '0;
               end
            end
            default: begin
               r_state <= ST_LOAD;
            end
         endcase
      end
   end

   assign lut_wr_ready     = w_wr_ready;
   assign lut_loaded       = (r_state == ST_RUN);
   assign data_in_0_ready  = w_in_ready;
   assign data_out_0_valid = r_out_valid;
   assign data_out_0       = r_out_data;

endmodule
